// File: rtl/game_pkg.sv
// Shared constants and state encoding for the runner game controller.
package game_pkg;
   localparam int SPEED_W = 4;
   localparam int LIVES_W = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      OVER  = 3'd4
   } game_state_t;
endpackage

// File: rtl/game_ctrl_frame_tick_gen.sv
// Vertical-sync falling-edge detector; emits one pulse per frame at the start of blanking.
module frame_tick_gen (
   input  logic CLK,
   input  logic RESET_N,
   input  logic vs,
   output logic frame_tick
);
   logic vs_r;
   logic tick_r;

   // Delay vs by one cycle and flag the 1->0 transition.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         vs_r   <= 1'b0;
         tick_r <= 1'b0;
      end else begin
         vs_r   <= vs;
         tick_r <= vs_r & ~vs;
      end
   end

   assign frame_tick = tick_r;
endmodule

// File: rtl/game_ctrl.sv
// Game-state controller: start/pause/over FSM, lives with post-hit immunity,
// frame-paced scoring and speed ramp for the VGA runner game.
module game_ctrl
   import game_pkg::*;
#(
   parameter int N_HAZARD         = 2,
   parameter int LIVES            = 3,
   parameter int SCORE_W          = 16,
   parameter int FRAMES_PER_POINT = 6,
   parameter int PTS_PER_SPEED    = 100,
   parameter int SPEED_MIN        = 1,
   parameter int SPEED_MAX        = 15,
   parameter int INVULN_FRAMES    = 60
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                start,
   input  logic                pause,
   input  logic                vs,
   input  logic                px_player,
   input  logic [N_HAZARD-1:0] px_hazard,
   output logic                game_status,
   output logic [2:0]          state,
   output logic [SCORE_W-1:0]  score,
   output logic [LIVES_W-1:0]  lives_left,
   output logic [SPEED_W-1:0]  speed,
   output logic                hit,
   output logic [N_HAZARD-1:0] hit_mask
);
   localparam int INV_W = $clog2(INVULN_FRAMES + 1);
   localparam int FC_W  = $clog2(FRAMES_PER_POINT + 1);
   localparam int PC_W  = $clog2(PTS_PER_SPEED + 1);
   localparam logic [SCORE_W-1:0] SCORE_SAT = {SCORE_W{1'b1}};

   game_state_t         state_r, state_nx_s;
   logic [SCORE_W-1:0]  score_r, score_nx_s;
   logic [LIVES_W-1:0]  lives_r, lives_nx_s;
   logic [SPEED_W-1:0]  speed_r, speed_nx_s;
   logic                hit_r, hit_nx_s;
   logic [N_HAZARD-1:0] hit_mask_r, hit_mask_nx_s;
   logic [INV_W-1:0]    invuln_r, invuln_nx_s;
   logic [FC_W-1:0]     frame_cnt_r, frame_cnt_nx_s;
   logic [PC_W-1:0]     pt_cnt_r, pt_cnt_nx_s;
   logic                start_lat_r, start_lat_nx_s;
   logic                frame_hit_r, frame_hit_nx_s;
   logic                game_status_r;
   logic                frame_tick_s;
   logic                coll_s;
   logic                final_hit_s;

   frame_tick_gen u_tick (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .vs         (vs),
      .frame_tick (frame_tick_s)
   );

   // At most one accepted hit per frame, and none while immune.
   assign coll_s = (state_r == RUN) && (invuln_r == INV_W'(0)) && !frame_hit_r
                   && px_player && (|px_hazard);
   assign final_hit_s = coll_s && (lives_r <= LIVES_W'(1));

   // Next-state and datapath decode; a final hit pre-empts the tick's score/pause work.
   always_comb begin
      state_nx_s     = state_r;
      score_nx_s     = score_r;
      lives_nx_s     = lives_r;
      speed_nx_s     = speed_r;
      hit_nx_s       = 1'b0;
      hit_mask_nx_s  = hit_mask_r;
      invuln_nx_s    = invuln_r;
      frame_cnt_nx_s = frame_cnt_r;
      pt_cnt_nx_s    = pt_cnt_r;
      start_lat_nx_s = start_lat_r;
      frame_hit_nx_s = frame_hit_r;

      if (((state_r == IDLE) || (state_r == OVER)) && start) begin
         start_lat_nx_s = 1'b1;
      end else begin
         start_lat_nx_s = start_lat_r;
      end

      if (coll_s) begin
         frame_hit_nx_s = 1'b1;
      end else if (frame_tick_s) begin
         frame_hit_nx_s = 1'b0;
      end else begin
         frame_hit_nx_s = frame_hit_r;
      end

      case (state_r)
         IDLE: begin
            if (start_lat_r) begin
               state_nx_s = ARMED;
            end else begin
               state_nx_s = IDLE;
            end
         end
         ARMED: begin
            if (frame_tick_s) begin
               state_nx_s     = RUN;
               score_nx_s     = SCORE_W'(0);
               lives_nx_s     = LIVES_W'(LIVES);
               speed_nx_s     = SPEED_W'(SPEED_MIN);
               hit_mask_nx_s  = N_HAZARD'(0);
               invuln_nx_s    = INV_W'(0);
               frame_cnt_nx_s = FC_W'(0);
               pt_cnt_nx_s    = PC_W'(0);
               start_lat_nx_s = 1'b0;
            end else begin
               state_nx_s = ARMED;
            end
         end
         RUN: begin
            if (coll_s) begin
               hit_nx_s      = 1'b1;
               hit_mask_nx_s = px_hazard;
               if (final_hit_s) begin
                  lives_nx_s = LIVES_W'(0);
                  state_nx_s = OVER;
               end else begin
                  lives_nx_s = lives_r - LIVES_W'(1);
               end
            end else begin
               hit_nx_s = 1'b0;
            end

            if (coll_s && !final_hit_s) begin
               invuln_nx_s = INV_W'(INVULN_FRAMES);
            end else if (frame_tick_s && (invuln_r != INV_W'(0))) begin
               invuln_nx_s = invuln_r - INV_W'(1);
            end else begin
               invuln_nx_s = invuln_r;
            end

            if (frame_tick_s && !final_hit_s) begin
               if (frame_cnt_r == FC_W'(FRAMES_PER_POINT - 1)) begin
                  frame_cnt_nx_s = FC_W'(0);
                  score_nx_s = (score_r == SCORE_SAT) ? score_r : score_r + SCORE_W'(1);
                  if (pt_cnt_r == PC_W'(PTS_PER_SPEED - 1)) begin
                     pt_cnt_nx_s = PC_W'(0);
                     speed_nx_s  = (speed_r == SPEED_W'(SPEED_MAX)) ? speed_r
                                                                    : speed_r + SPEED_W'(1);
                  end else begin
                     pt_cnt_nx_s = pt_cnt_r + PC_W'(1);
                  end
               end else begin
                  frame_cnt_nx_s = frame_cnt_r + FC_W'(1);
               end
               if (pause) begin
                  state_nx_s = PAUSE;
               end else begin
                  state_nx_s = RUN;
               end
            end else begin
               frame_cnt_nx_s = frame_cnt_r;
            end
         end
         PAUSE: begin
            if (frame_tick_s && !pause) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = PAUSE;
            end
         end
         OVER: begin
            if (start_lat_r) begin
               state_nx_s = ARMED;
            end else begin
               state_nx_s = OVER;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Game state registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r       <= IDLE;
         score_r       <= SCORE_W'(0);
         lives_r       <= LIVES_W'(LIVES);
         speed_r       <= SPEED_W'(SPEED_MIN);
         hit_r         <= 1'b0;
         hit_mask_r    <= N_HAZARD'(0);
         invuln_r      <= INV_W'(0);
         frame_cnt_r   <= FC_W'(0);
         pt_cnt_r      <= PC_W'(0);
         start_lat_r   <= 1'b0;
         frame_hit_r   <= 1'b0;
         game_status_r <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         score_r       <= score_nx_s;
         lives_r       <= lives_nx_s;
         speed_r       <= speed_nx_s;
         hit_r         <= hit_nx_s;
         hit_mask_r    <= hit_mask_nx_s;
         invuln_r      <= invuln_nx_s;
         frame_cnt_r   <= frame_cnt_nx_s;
         pt_cnt_r      <= pt_cnt_nx_s;
         start_lat_r   <= start_lat_nx_s;
         frame_hit_r   <= frame_hit_nx_s;
         game_status_r <= (state_nx_s == RUN);
      end
   end

   assign game_status = game_status_r;
   assign state       = state_r;
   assign score       = score_r;
   assign lives_left  = lives_r;
   assign speed       = speed_r;
   assign hit         = hit_r;
   assign hit_mask    = hit_mask_r;
endmodule
